// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared pipeline constants and types
package common_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with push, pop, flush and occupancy count
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0],
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    input  logic          flush,
    output T              head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, credit-limited imem requests, instruction buffer, redirect
module fetch_stage
    import common_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] pc_branch,
    input  logic        insert_bubble,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_decode
);

    localparam int          CW      = $clog2(IBUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(IBUF_DEPTH);

    logic [31:0]   pc_q;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_cnt;
    logic [CW-1:0] side_cnt;
    logic [31:0]   side_pc;
    fetch_entry_t  buf_in;
    fetch_entry_t  buf_head;
    logic [CW:0]   occ_buf;
    logic [CW:0]   occ_mem;
    logic          accept;
    logic          rsp_live;
    logic          rsp_drop;
    logic          buf_push;
    logic          buf_pop;

    // Two credits: buffer space for every live request, and side-FIFO space for every outstanding one.
    assign occ_buf = {1'b0, live_cnt} + {1'b0, buf_cnt};
    assign occ_mem = {1'b0, live_cnt} + {1'b0, drop_cnt};

    assign imem_req_valid = rst && !branch_taken && (occ_buf < DEPTH_W) && (occ_mem < DEPTH_W);
    assign imem_addr      = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // Stale responses are always the oldest outstanding, so they drain first.
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_live = imem_rsp_valid && (drop_cnt == '0);
    assign buf_push = rsp_live && !branch_taken;
    assign buf_pop  = instr_valid && !insert_bubble && !branch_taken;
    assign buf_in   = '{pc: side_pc, instr: imem_rsp_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            live_cnt <= '0;
            drop_cnt <= '0;
        end else if (branch_taken) begin
            pc_q     <= pc_branch & 32'hFFFF_FFFC;
            live_cnt <= '0;
            drop_cnt <= drop_cnt + live_cnt - CW'(imem_rsp_valid);
        end else begin
            if (accept) pc_q <= pc_q + 32'd4;
            live_cnt <= live_cnt + CW'(accept) - CW'(rsp_live);
            drop_cnt <= drop_cnt - CW'(rsp_drop);
        end
    end

    fetch_fifo #(
        .DEPTH (IBUF_DEPTH),
        .T     (logic [31:0])
    ) u_side_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (pc_q),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .head      (side_pc),
        .count     (side_cnt)
    );

    fetch_fifo #(
        .DEPTH (IBUF_DEPTH),
        .T     (fetch_entry_t)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .flush     (branch_taken),
        .head      (buf_head),
        .count     (buf_cnt)
    );

    assign instr_valid = (buf_cnt != '0);
    assign instruction = instr_valid ? buf_head.instr : INSTR_NOP;
    assign pc_decode   = instr_valid ? buf_head.pc : 32'h0;

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (live_cnt != '0 || drop_cnt != '0));

    a_side_tracks: assert property (@(posedge clk) disable iff (!rst)
        side_cnt == live_cnt + drop_cnt);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a queue-based reference model
module tb_fetch_stage;
    import common_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          D   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] pc_branch = 32'h0;
    logic        insert_bubble = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc_decode;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC), .IBUF_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .branch_taken   (branch_taken),
        .pc_branch      (pc_branch),
        .insert_bubble  (insert_bubble),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .pc_decode      (pc_decode)
    );

    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } be_t;
    typedef struct { logic [31:0] addr; int due; } mr_t;

    fl_t         infl[$];
    be_t         bufq[$];
    mr_t         memq[$];
    logic [31:0] mpc;
    int          cyc, last_due, lat_min, lat_max;
    bit          rand_mode;
    int          n_checks, n_fail;
    logic        s_rv, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instruction", instruction, 32'h0000_0013);
        chk("rst_pc_decode", pc_decode, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_imem_addr", imem_addr, RPC);
    endtask

    task automatic release_reset();
        infl.delete();
        bufq.delete();
        memq.delete();
        mpc            = RPC;
        imem_rsp_valid = 1'b0;
        branch_taken   = 1'b0;
        insert_bubble  = 1'b0;
        imem_req_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        cyc      = 0;
        last_due = -1;
    endtask

    // One clock: compare at the falling edge, advance model and memory, then drive the next cycle.
    task automatic cycle();
        int  live, drop, due;
        bit  exp_rv, acc, pop_head;
        fl_t e;
        @(negedge clk);
        s_rv = imem_req_valid; s_addr = imem_addr;
        s_valid = instr_valid; s_instr = instruction; s_pc = pc_decode;
        live = 0; drop = 0;
        foreach (infl[i]) if (infl[i].stale) drop++; else live++;
        exp_rv = !branch_taken && (live + bufq.size() < D) && (live + drop < D);
        chk("req_valid", {31'b0, s_rv}, {31'b0, exp_rv});
        chk("imem_addr", s_addr, mpc);
        if (bufq.size() > 0) begin
            chk("instr_valid", {31'b0, s_valid}, 32'd1);
            chk("instruction", s_instr, bufq[0].ins);
            chk("pc_decode", s_pc, bufq[0].pc);
        end else begin
            chk("instr_valid", {31'b0, s_valid}, 32'd0);
            chk("instruction", s_instr, INSTR_NOP);
            chk("pc_decode", s_pc, 32'h0);
        end
        if (s_rv && imem_req_ready) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            memq.push_back('{addr: s_addr, due: due});
            last_due = due;
        end
        acc      = exp_rv && imem_req_ready;
        pop_head = (bufq.size() > 0) && !insert_bubble && !branch_taken;
        if (branch_taken) begin
            if (imem_rsp_valid && infl.size() > 0) void'(infl.pop_front());
            bufq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            mpc = {pc_branch[31:2], 2'b00};
        end else begin
            if (pop_head) void'(bufq.pop_front());
            if (imem_rsp_valid && infl.size() > 0) begin
                e = infl.pop_front();
                if (!e.stale) bufq.push_back('{pc: e.pc, ins: imem_rsp_data});
            end
            if (acc) begin
                infl.push_back('{pc: mpc, stale: 1'b0});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq[0].addr ^ 32'hA5A5_0000;
            void'(memq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if (rand_mode) begin
            imem_req_ready = ($urandom_range(9, 0) < 8);
            insert_bubble  = ($urandom_range(3, 0) == 0);
            branch_taken   = ($urandom_range(15, 0) == 0);
            pc_branch      = $urandom;
        end
    endtask

    initial begin
        int k;
        n_checks = 0; n_fail = 0; rand_mode = 1'b0;
        lat_min = 1; lat_max = 1; cyc = 0; last_due = -1;
        #1;
        chk_reset_outputs();
        release_reset();

        // Streaming with 1-cycle memory
        cycle(); chk("first_req_valid", {31'b0, s_rv}, 32'd1); chk("first_req_addr", s_addr, 32'h0);
        cycle(); chk("cycle1_empty", {31'b0, s_valid}, 32'd0);
        cycle(); chk("cycle2_pc", s_pc, 32'h0); chk("cycle2_instr", s_instr, 32'hA5A5_0000);
        cycle(); chk("cycle3_pc", s_pc, 32'h4); chk("cycle3_instr", s_instr, 32'hA5A5_0004);

        // Three-cycle stall at pc_decode 0x8
        insert_bubble = 1'b1;
        repeat (3) begin cycle(); chk("stall_hold_pc", s_pc, 32'h8); end
        insert_bubble = 1'b0;
        cycle(); chk("stall_release_pc", s_pc, 32'h8);
        cycle(); chk("resume_pc", s_pc, 32'hC); chk("resume_instr", s_instr, 32'hA5A5_000C);
        cycle(); chk("resume_next_pc", s_pc, 32'h10);

        // Redirect with two requests outstanding on a 3-cycle memory
        rst = 1'b0;
        #1;
        release_reset();
        lat_min = 3; lat_max = 3;
        cycle(); cycle();
        branch_taken = 1'b1; pc_branch = 32'h0000_0103;
        cycle(); chk("redirect_no_req", {31'b0, s_rv}, 32'd0);
        branch_taken = 1'b0;
        k = 0;
        do begin cycle(); k++; end while (!s_valid && k < 20);
        chk("redirect_found", {31'b0, s_valid}, 32'd1);
        chk("redirect_pc", s_pc, 32'h100);
        chk("redirect_instr", s_instr, 32'hA5A5_0100);
        chk("redirect_cycle", cyc - 1, 32'd7);

        // Redirect and stall in the same cycle
        lat_min = 1; lat_max = 1;
        repeat (10) cycle();
        branch_taken = 1'b1; insert_bubble = 1'b1; pc_branch = 32'h0000_0200;
        cycle();
        branch_taken = 1'b0; insert_bubble = 1'b0;
        cycle(); chk("flush_b1_empty", {31'b0, s_valid}, 32'd0);
        cycle(); chk("flush_b2_empty", {31'b0, s_valid}, 32'd0);
        cycle(); chk("flush_b3_valid", {31'b0, s_valid}, 32'd1); chk("flush_b3_pc", s_pc, 32'h200);

        // Memory not ready for four cycles
        imem_req_ready = 1'b0;
        repeat (4) begin
            cycle();
            chk("notready_req_valid", {31'b0, s_rv}, 32'd1);
            chk("notready_addr", s_addr, 32'h20C);
        end
        imem_req_ready = 1'b1;
        cycle(); chk("ready_addr", s_addr, 32'h20C);
        cycle(); chk("ready_next_addr", s_addr, 32'h210);
        repeat (6) cycle();

        // Asynchronous reset mid-stream
        #3 rst = 1'b0;
        #1;
        chk_reset_outputs();
        release_reset();
        cycle(); chk("restart_addr", s_addr, RPC);
        cycle();
        cycle(); chk("restart_pc", s_pc, RPC); chk("restart_valid", {31'b0, s_valid}, 32'd1);

        // Randomized traffic
        lat_min = 1; lat_max = 5; rand_mode = 1'b1;
        repeat (3000) cycle();
        rand_mode = 1'b0;
        branch_taken = 1'b0; insert_bubble = 1'b0; imem_req_ready = 1'b1;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
